shift_rows_pipe: RTL and testbench

//  Registered, flow-controlled Rijndael ShiftRows stage, the next generation of the combinational 4x4 permutation.

---
 rtl/shift_rows_pkg.sv | 25 ++
 rtl/shift_rows_perm.sv | 30 +++
 rtl/shift_rows_pipe.sv | 102 ++++++++++
 tb/tb_shift_rows_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_rows_pkg.sv
// Shared types and helpers for the ShiftRows pipeline stage.
// shift_off() is only ever evaluated at elaboration to build the fixed
// byte routing; it never becomes runtime logic.
package shift_rows_pkg;

    typedef logic [7:0] byte_t;

    localparam int MAX_NB = 8;
    localparam int ROWS   = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Rijndael row rotation amount: 256-bit blocks use 0,1,3,4.
    function automatic int shift_off(int nb, int row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte routing for an NB-column state.
// With SHIFT_ROWS_INV_EN defined an inv input selects the inverse rotation;
// otherwise only the forward routing exists.
module shift_rows_perm
    import shift_rows_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [ROWS-1:0][NB-1:0][7:0] in_state,
`ifdef SHIFT_ROWS_INV_EN
    input  logic                         inv,
`endif
    output logic [ROWS-1:0][NB-1:0][7:0] out_state
);

    // Pure wiring: each output cell picks a fixed source column per direction.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int SH  = shift_off(NB, r);
            localparam int FWD = (c + SH) % NB;
`ifdef SHIFT_ROWS_INV_EN
            localparam int INV = (c - SH + NB) % NB;
            assign out_state[r][c] = inv ? in_state[r][INV] : in_state[r][FWD];
`else
            assign out_state[r][c] = in_state[r][FWD];
`endif
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered, valid/ready ShiftRows stage with a two-entry skid (M drives the
// outputs, S absorbs one beat while M is held). Permutation happens before the
// register, so latency is one cycle and throughput is one beat per cycle.
// Optional feature macro: SHIFT_ROWS_INV_EN adds the per-beat in_inv select;
// direction is resolved before storage, so each stored beat already reflects it.
//
// occupancy | meaning
// ----------+---------------------------------------------
// EMPTY     | M and S empty, out_valid=0, in_ready=1
// ONE       | M holds a beat, S empty, in_ready=1
// TWO       | M held with S full, in_ready=0
module shift_rows_pipe
    import shift_rows_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ROWS-1:0][NB-1:0][7:0] in_state,
`ifdef SHIFT_ROWS_INV_EN
    input  logic                         in_inv,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ROWS-1:0][NB-1:0][7:0] out_state
);

    if (!(NB == 4 || NB == 6 || NB == 8) || NB > MAX_NB) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (ROWS != 4) begin : g_bad_rows
        $error("shift_rows_pipe: ROWS must be 4");
    end

    occ_e                        occ;
    byte_t [ROWS-1:0][NB-1:0]    perm_data;
    byte_t [ROWS-1:0][NB-1:0]    m_data;
    byte_t [ROWS-1:0][NB-1:0]    s_data;
    logic                        acc;
    logic                        drn;

    assign acc = in_valid & in_ready;
    assign drn = out_valid & out_ready;

    shift_rows_perm #(.NB(NB)) u_perm (
        .in_state  (in_state),
`ifdef SHIFT_ROWS_INV_EN
        .inv       (in_inv),
`endif
        .out_state (perm_data)
    );

    // Occupancy FSM: data only moves on a handshake, so idle input X never lands in M or S.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= OCC_EMPTY;
            m_data    <= '0;
            s_data    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (acc) begin
                        m_data    <= perm_data;
                        out_valid <= 1'b1;
                        occ       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (acc && drn) begin
                        m_data <= perm_data;
                    end else if (acc) begin
                        s_data   <= perm_data;
                        in_ready <= 1'b0;
                        occ      <= OCC_TWO;
                    end else if (drn) begin
                        out_valid <= 1'b0;
                        occ       <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (drn) begin
                        m_data   <= s_data;
                        in_ready <= 1'b1;
                        occ      <= OCC_ONE;
                    end
                end
                default: begin
                    occ       <= OCC_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_state = m_data;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: hand-computed AES vectors, NB=8 offsets,
// stall/skid streaming, mid-operation reset and a randomized scoreboard run.
module tb_shift_rows_pipe;

    typedef logic [3:0][3:0][7:0] st4_t;
    typedef logic [3:0][7:0][7:0] st8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v4 = 1'b0, r4, ov4, ordy4 = 1'b0, inv4 = 1'b0;
    st4_t d4 = '0, q4;
    logic v8 = 1'b0, r8, ov8, ordy8 = 1'b0, inv8 = 1'b0;
    st8_t d8 = '0, q8;

    shift_rows_pipe #(.NB(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_state(d4),
`ifdef SHIFT_ROWS_INV_EN
        .in_inv(inv4),
`endif
        .out_valid(ov4), .out_ready(ordy4), .out_state(q4));

    shift_rows_pipe #(.NB(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_state(d8),
`ifdef SHIFT_ROWS_INV_EN
        .in_inv(inv8),
`endif
        .out_valid(ov8), .out_ready(ordy8), .out_state(q8));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference ShiftRows for NB=4 (offsets 0,1,2,3).
    function automatic st4_t ref4(input st4_t s, input logic inv);
        st4_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = inv ? s[r][(c - r + 4) % 4] : s[r][(c + r) % 4];
        return o;
    endfunction

    function automatic st4_t mkbeat(input int b);
        st4_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = 8'(b * 16 + r * 4 + c);
        return s;
    endfunction

    st4_t exp_q[$];
    st4_t prev_q = '0;
    logic prev_hold = 1'b0;
    logic prev_fill = 1'b0;
    int   n_out = 0;

    // One cycle on the NB=4 instance: drive, sample at negedge, score, advance.
    task automatic step(input logic vin, input st4_t din, input logic iinv,
                        input logic ordy, output logic accepted);
        v4 = vin; d4 = din; inv4 = iinv; ordy4 = ordy;
        @(negedge clk);
        if (prev_hold) chk("stall_stable", q4, prev_q);
        if (prev_fill) chk("ready_drop", r4, 1'b0);
        if (ov4) chk("no_x", $isunknown(q4), 1'b0);
        accepted = vin && r4;
        if (ov4 && ordy) begin
            if (exp_q.size() == 0) chk("spurious", 1'b1, 1'b0);
            else chk("beat", q4, exp_q.pop_front());
            n_out++;
        end
        if (accepted) exp_q.push_back(ref4(din, iinv));
        prev_fill = accepted && ov4 && !ordy;
        prev_hold = ov4 && !ordy;
        prev_q = q4;
        @(posedge clk); #1;
    endtask

    st4_t vv, e_fwd, e_inv, blk_a, blk_b;
    logic acc;
    int   bi, k, cyc, n_acc;

    initial begin
        vv[0] = {8'hA0, 8'h9F, 8'hEB, 8'h63};
        vv[1] = {8'h92, 8'h93, 8'h2F, 8'hC0};
        vv[2] = {8'hC7, 8'hAF, 8'h30, 8'hAB};
        vv[3] = {8'hA2, 8'h2B, 8'hCB, 8'h20};
        e_fwd[0] = {8'hA0, 8'h9F, 8'hEB, 8'h63};
        e_fwd[1] = {8'hC0, 8'h92, 8'h93, 8'h2F};
        e_fwd[2] = {8'h30, 8'hAB, 8'hC7, 8'hAF};
        e_fwd[3] = {8'h2B, 8'hCB, 8'h20, 8'hA2};
        e_inv[0] = {8'hA0, 8'h9F, 8'hEB, 8'h63};
        e_inv[1] = {8'h93, 8'h2F, 8'hC0, 8'h92};
        e_inv[2] = {8'h30, 8'hAB, 8'hC7, 8'hAF};
        e_inv[3] = {8'h20, 8'hA2, 8'h2B, 8'hCB};

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_out_state", q4, 128'd0);
        chk("rst_in_ready", r4, 1'b1);

        // 1: forward AES vector
        v4 = 1'b1; d4 = vv; inv4 = 1'b0; ordy4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("fwd_valid", ov4, 1'b1);
        chk("fwd_state", q4, e_fwd);
        @(posedge clk); #1;
        chk("fwd_drained", ov4, 1'b0);

`ifdef SHIFT_ROWS_INV_EN
        // 2: inverse, then forward of that result restores V
        v4 = 1'b1; d4 = vv; inv4 = 1'b1;
        @(posedge clk); #1;
        chk("inv_state", q4, e_inv);
        d4 = e_inv; inv4 = 1'b0;
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("roundtrip_valid", ov4, 1'b1);
        chk("roundtrip_state", q4, vv);
        @(posedge clk); #1;
`endif

        // 3: NB=8 offsets 0,1,3,4
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                d8[r][c] = 8'(r * 16 + c);
        v8 = 1'b1; ordy8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        chk("nb8_valid", ov8, 1'b1);
        chk("nb8_r0c5", q8[0][5], 8'h05);
        chk("nb8_r1c7", q8[1][7], 8'h10);
        chk("nb8_r2c0", q8[2][0], 8'h23);
        chk("nb8_r3c0", q8[3][0], 8'h34);
        chk("nb8_r3c7", q8[3][7], 8'h33);

        // 4: 10-beat stream, out_ready low for cycles 3..6
        exp_q.delete(); n_out = 0; prev_hold = 1'b0; prev_fill = 1'b0;
        bi = 0; k = 0;
        while (n_out < 10 && k < 60) begin
            step(bi < 10, mkbeat(bi), 1'b0, !(k >= 3 && k <= 6), acc);
            if (acc) bi++;
            k++;
        end
        chk("stream_count", n_out, 10);
        chk("stream_cycles", k, 15);

        // 5: reset with M and S both full
        v4 = 1'b1; ordy4 = 1'b0; blk_a = mkbeat(11); blk_b = mkbeat(12);
        d4 = blk_a;
        @(posedge clk); #1;
        d4 = blk_b;
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("full_in_ready", r4, 1'b0);
        chk("full_out_valid", ov4, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov4, 1'b0);
        chk("midrst_out_state", q4, 128'd0);
        chk("midrst_in_ready", r4, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", r4, 1'b1);
        v4 = 1'b1; d4 = vv; inv4 = 1'b0; ordy4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("post_rst_first", q4, e_fwd);
        @(posedge clk); #1;

        // 6: random traffic against the scoreboard
        exp_q.delete(); n_out = 0; prev_hold = 1'b0; prev_fill = 1'b0;
        n_acc = 0; cyc = 0;
        while (n_acc < 2000 && cyc < 20000) begin
            logic vin, iinv;
            st4_t din;
            vin = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    din[r][c] = 8'($urandom);
            if (!vin) din = 'x;
`ifdef SHIFT_ROWS_INV_EN
            iinv = 1'($urandom_range(0, 1));
`else
            iinv = 1'b0;
`endif
            step(vin, din, iinv, ($urandom_range(0, 2) != 0), acc);
            if (acc) n_acc++;
            cyc++;
        end
        chk("rand_accepted", n_acc, 2000);
        while (exp_q.size() > 0 && cyc < 22000) begin
            step(1'b0, '0, 1'b0, 1'b1, acc);
            cyc++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_out_count", n_out, 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
